// File: rtl/but_debounce.sv
// Multi-channel button debouncer: 2-flop synchroniser, saturating stable-cycle counter, edge pulses.
// Optional per-channel toggle outputs are built only when BUT_DEBOUNCE_TOGGLE_EN is defined.
module but_debounce #(
  parameter int WIDTH      = 2,
  parameter int DB_CYCLES  = 120000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] but_raw,
  output logic [WIDTH-1:0] but,
  output logic [WIDTH-1:0] but_rise,
  output logic [WIDTH-1:0] but_fall,
  output logic [WIDTH-1:0] but_tgl
);

  localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] w_norm;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Normalise to active-high before synchronising so reset value 0 means "released".
  assign w_norm = ACTIVE_LOW ? ~but_raw : but_raw;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_norm;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_but;
    logic          r_rise;
    logic          r_fall;

    // Any cycle that agrees with the accepted level restarts the count, so glitches never accumulate.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_cnt  <= '0;
        r_but  <= 1'b0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (r_sync2[gi] == r_but) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_cnt  <= '0;
          r_but  <= r_sync2[gi];
          r_rise <= r_sync2[gi];
          r_fall <= ~r_sync2[gi];
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end

    assign but[gi]      = r_but;
    assign but_rise[gi] = r_rise;
    assign but_fall[gi] = r_fall;

`ifdef BUT_DEBOUNCE_TOGGLE_EN
    logic r_tgl;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_tgl <= 1'b0;
      end else if (r_rise) begin
        r_tgl <= ~r_tgl;
      end
    end

    assign but_tgl[gi] = r_tgl;
`else
    assign but_tgl[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_but_debounce.sv
// Table-driven bench for but_debounce (DB_CYCLES=4, WIDTH=2, active-low pins) plus latency sequences.
module tb_but_debounce;

  localparam int WIDTH = 2;
  localparam int DB    = 4;
`ifdef BUT_DEBOUNCE_TOGGLE_EN
  localparam bit TGL_EN = 1'b1;
`else
  localparam bit TGL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic [WIDTH-1:0] but_raw;
  logic [WIDTH-1:0] but, but_rise, but_fall, but_tgl;
  logic [WIDTH-1:0] but1, but_rise1, but_fall1, but_tgl1;

  but_debounce #(.WIDTH(WIDTH), .DB_CYCLES(DB), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .but_raw(but_raw),
    .but(but), .but_rise(but_rise), .but_fall(but_fall), .but_tgl(but_tgl)
  );

  but_debounce #(.WIDTH(WIDTH), .DB_CYCLES(1), .ACTIVE_LOW(1'b1)) u_dut1 (
    .clk(clk), .rstn(rstn), .but_raw(but_raw),
    .but(but1), .but_rise(but_rise1), .but_fall(but_fall1), .but_tgl(but_tgl1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [1:0] raw;
    logic [1:0] but;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t vecs[256];
  int   n_vec = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic void add(logic r, logic [1:0] raw, logic [1:0] b,
                              logic [1:0] ri, logic [1:0] fa, int n);
    for (int k = 0; k < n; k++) begin
      vecs[n_vec].rstn = r;
      vecs[n_vec].raw  = raw;
      vecs[n_vec].but  = b;
      vecs[n_vec].rise = ri;
      vecs[n_vec].fall = fa;
      n_vec++;
    end
  endfunction

  task automatic check(string name, int idx, logic [1:0] act, logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int lo, int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One press (raw low) and release on a channel mask, expecting the DB=4 timing.
  function automatic void press_release(logic [1:0] m);
    add(1'b1, ~m, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, ~m, m,     m,     2'b00, 1);
    add(1'b1, ~m, m,     2'b00, 2'b00, 3);
    add(1'b1, 2'b11, m,     2'b00, 2'b00, 5);
    add(1'b1, 2'b11, 2'b00, 2'b00, m,     1);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 3);
  endfunction

  logic [1:0] exp_tgl;
  logic [1:0] pend_tgl;
  int         cyc, lat4, lat1, extra;

  initial begin
    rstn    = 1'b0;
    but_raw = 2'b11;
    exp_tgl  = 2'b00;
    pend_tgl = 2'b00;

    // Reset, then idle release: no activity at all.
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 3);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 20);
    // Clean press/release on channel 0.
    press_release(2'b01);
    // Bounce on channel 1: glitches never reach the 4-cycle threshold.
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1);
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1);
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b01, 2'b10, 2'b10, 2'b00, 1);
    add(1'b1, 2'b01, 2'b10, 2'b00, 2'b00, 3);
    add(1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 5);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b10, 1);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 3);
    // Both channels together, then two more channel-0 presses for the toggle.
    press_release(2'b11);
    press_release(2'b01);
    press_release(2'b01);
    // Reset mid-count (count reaches 2), button held through and after reset.
    add(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 4);
    add(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2);
    add(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b10, 2'b01, 2'b01, 2'b00, 1);
    add(1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 3);
    add(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 5);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b01, 1);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 3);

    for (int i = 0; i < n_vec; i++) begin
      rstn    = vecs[i].rstn;
      but_raw = vecs[i].raw;
      @(posedge clk);
      #1;
      if (!vecs[i].rstn) begin
        exp_tgl  = 2'b00;
        pend_tgl = 2'b00;
      end else begin
        if (TGL_EN) exp_tgl = exp_tgl ^ pend_tgl;
        pend_tgl = vecs[i].rise;
      end
      $display("[TB] vec %0d rstn=%b raw=%b but=%b rise=%b fall=%b tgl=%b",
               i, rstn, but_raw, but, but_rise, but_fall, but_tgl);
      check("but",       i, but,                 vecs[i].but);
      check("but_rise",  i, but_rise,            vecs[i].rise);
      check("but_fall",  i, but_fall,            vecs[i].fall);
      check("but_tgl",   i, but_tgl,             exp_tgl);
      check("rise_fall", i, but_rise & but_fall, 2'b00);
    end

    // Latency on both instances from one clean press on channel 0 (DB=4 -> 6, DB=1 -> 3).
    but_raw = 2'b10;
    lat4 = 0;
    lat1 = 0;
    for (cyc = 1; cyc <= 20 && (lat4 == 0 || lat1 == 0); cyc++) begin
      @(posedge clk);
      #1;
      if (but_rise[0] && lat4 == 0) lat4 = cyc;
      if (but_rise1[0] && lat1 == 0) lat1 = cyc;
    end
    $display("[TB] press latency db4=%0d db1=%0d", lat4, lat1);
    check_int("press_latency_db4", lat4, 6, 7);
    check_int("press_latency_db1", lat1, 3, 4);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (but_rise[0] || but_rise[1] || but_rise1[1]) extra++;
    end
    check_int("extra_rise", extra, 0, 0);
    check("held_but_db4", 0, but,  2'b01);
    check("held_but_db1", 0, but1, 2'b01);

    but_raw = 2'b11;
    lat4 = 0;
    lat1 = 0;
    for (cyc = 1; cyc <= 20 && (lat4 == 0 || lat1 == 0); cyc++) begin
      @(posedge clk);
      #1;
      if (but_fall[0] && lat4 == 0) lat4 = cyc;
      if (but_fall1[0] && lat1 == 0) lat1 = cyc;
    end
    $display("[TB] release latency db4=%0d db1=%0d", lat4, lat1);
    check_int("release_latency_db4", lat4, 6, 7);
    check_int("release_latency_db1", lat1, 3, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
